// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: hex decode, per-digit dp/blank, PWM brightness,
// dark guard interval between digits, and frame-synchronous double-buffered register updates.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 2,
    parameter int CLK_HZ       = 50_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int GUARD_CYCLES = 16,
    parameter int PWM_BITS     = 4
) (
    input  logic                    clkin_50,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    input  logic [PWM_BITS-1:0]     wr_bright,
    output logic                    wr_ready,
    output logic [7:0]              seg7_data,
    output logic [NUM_DIGITS-1:0]   seg7_char,
    output logic                    frame_done
);

    localparam int DWELL = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PWM_BITS-1:0]     pwm_q, pwm_d;
    logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d, pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic [PWM_BITS-1:0]     act_bright_q, act_bright_d, pend_bright_q, pend_bright_d;
    logic                    ready_q, ready_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   char_q, char_d;
    logic                    fd_q, fd_d;
    logic                    frame_end_s;
    logic [3:0]              nib_s;

    // Scan sequencer: guard/on slot timing, digit index and free-running PWM counter
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        pwm_d       = pwm_q + PWM_BITS'(1);
        frame_end_s = 1'b0;
        case (state_q)
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            ST_ON: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        frame_end_s = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase
    end

    // Double buffer: apply at frame end takes priority; a write landing on the boundary waits a frame
    always_comb begin
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
        act_bright_d  = act_bright_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_bright_d = pend_bright_q;
        ready_d       = ready_q;
        if (frame_end_s && !ready_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            act_bright_d = pend_bright_q;
            ready_d      = 1'b1;
        end else if (wr_en && ready_q) begin
            pend_data_d   = wr_data;
            pend_dp_d     = wr_dp;
            pend_blank_d  = wr_blank;
            pend_bright_d = wr_bright;
            ready_d       = 1'b0;
        end else begin
            ready_d = ready_q;
        end
    end

    // Pin drive computed from current scan state, registered one cycle later
    always_comb begin
        seg_d  = '0;
        char_d = '0;
        fd_d   = frame_end_s;
        nib_s  = act_data_q[{idx_q, 2'b00} +: 4];
        if (state_q == ST_ON) begin
            char_d[idx_q] = 1'b1;
            if (!act_blank_q[idx_q] && (pwm_q < act_bright_q)) begin
                seg_d = {act_dp_q[idx_q], hex_to_seg(nib_s)};
            end else begin
                seg_d = '0;
            end
        end else begin
            seg_d  = '0;
            char_d = '0;
        end
    end

    // State, buffer and output registers
    always_ff @(posedge clkin_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_GUARD;
            cnt_q         <= '0;
            idx_q         <= '0;
            pwm_q         <= '0;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            act_bright_q  <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_bright_q <= '0;
            ready_q       <= 1'b1;
            seg_q         <= '0;
            char_q        <= '0;
            fd_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pwm_q         <= pwm_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            act_bright_q  <= act_bright_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_bright_q <= pend_bright_d;
            ready_q       <= ready_d;
            seg_q         <= seg_d;
            char_q        <= char_d;
            fd_q          <= fd_d;
        end
    end

    assign wr_ready   = ready_q;
    assign seg7_data  = seg_q;
    assign seg7_char  = char_q;
    assign frame_done = fd_q;

endmodule
